// File: rtl/fi_inject_ctrl_if.sv
// Bus for the fault-injection controller: campaign request/config in, override
// drive and status out. clk and reset stay plain ports on the block.
interface fi_inject_ctrl_if #(
  parameter int CNT_W   = 16,
  parameter int NUM_TGT = 3
);
  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   cfg_delay;
  logic [CNT_W-1:0]   cfg_duration;
  logic [NUM_TGT-1:0] cfg_target;
  logic [1:0]         cfg_mode;
  logic [NUM_TGT-1:0] obs;

  logic [NUM_TGT-1:0] fi_en;
  logic [NUM_TGT-1:0] fi_val;
  logic               busy;
  logic               done;
  logic               err_cfg;
  logic [NUM_TGT-1:0] snap;
  logic [15:0]        inj_count;

  // Requester side: issues campaigns, observes the controller.
  modport master (
    output start, abort, cfg_delay, cfg_duration, cfg_target, cfg_mode, obs,
    input  fi_en, fi_val, busy, done, err_cfg, snap, inj_count
  );

  // Controller side.
  modport slave (
    input  start, abort, cfg_delay, cfg_duration, cfg_target, cfg_mode, obs,
    output fi_en, fi_val, busy, done, err_cfg, snap, inj_count
  );
endinterface

// File: rtl/fi_inject_ctrl.sv
// Fault-injection campaign controller: waits cfg_delay cycles after start, then
// overrides the selected datapath flops for cfg_duration cycles.
module fi_inject_ctrl #(
  parameter int CNT_W   = 16,
  parameter int NUM_TGT = 3
) (
  input  logic           clk,
  input  logic           reset,
  fi_inject_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    INJECT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] MODE_FLIP = 2'd0;
  localparam logic [1:0] MODE_SA0  = 2'd1;
  localparam logic [1:0] MODE_SA1  = 2'd2;
  localparam logic [1:0] MODE_BAD  = 2'd3;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   dur_q;
  logic [NUM_TGT-1:0] tgt_q;
  logic [1:0]         mode_q;
  logic [NUM_TGT-1:0] snap_q;
  logic [NUM_TGT-1:0] fi_en_q, fi_en_d;
  logic [NUM_TGT-1:0] fi_val_q, fi_val_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        inj_count_q;

  logic               cfg_bad;
  logic               load_cfg;
  logic               capture;
  logic               count_inc;
  logic [NUM_TGT-1:0] pattern;

  assign cfg_bad = (bus.cfg_target == '0) || (bus.cfg_duration == '0) ||
                   (bus.cfg_mode == MODE_BAD);

  // Override pattern is built only from latched mode and the snapshot, so the
  // drive into the datapath never follows live obs.
  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_FLIP: pattern = ~snap_q;
      MODE_SA0:  pattern = '0;
      MODE_SA1:  pattern = '1;
      default:   pattern = '0;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_cfg  = 1'b0;
    capture   = 1'b0;
    count_inc = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (bus.abort) begin
      // Abort outranks everything; in IDLE it simply swallows a start.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (cfg_bad) begin
              err_d = 1'b1;
            end else begin
              state_d  = WAIT;
              cnt_d    = bus.cfg_delay;
              load_cfg = 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_d = INJECT;
            cnt_d   = dur_q - CNT_W'(1);
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        INJECT: begin
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_d   = IDLE;
          count_inc = 1'b1;
          done_d    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Override outputs lag the INJECT state by one register stage; an abort
    // seen on the same edge suppresses them immediately.
    fi_en_d  = '0;
    fi_val_d = '0;
    if (!bus.abort && state_q == INJECT) begin
      fi_en_d  = tgt_q;
      fi_val_d = pattern & tgt_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fi_en_q     <= '0;
      fi_val_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      snap_q      <= '0;
      inj_count_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fi_en_q  <= fi_en_d;
      fi_val_q <= fi_val_d;
      done_q   <= done_d;
      err_q    <= err_d;
      if (capture) begin
        snap_q <= bus.obs;
      end
      if (count_inc && inj_count_q != 16'hFFFF) begin
        inj_count_q <= inj_count_q + 16'd1;
      end
    end
  end

  // NOTE: the latched campaign config is left unreset on purpose; it is always
  // written on an accepted start before anything reads it.
  always_ff @(posedge clk) begin
    if (load_cfg) begin
      dur_q  <= bus.cfg_duration;
      tgt_q  <= bus.cfg_target;
      mode_q <= bus.cfg_mode;
    end
  end

  assign bus.fi_en     = fi_en_q;
  assign bus.fi_val    = fi_val_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.err_cfg   = err_q;
  assign bus.snap      = snap_q;
  assign bus.inj_count = inj_count_q;

endmodule

// File: tb/tb_fi_inject_ctrl.sv
// Directed bench for fi_inject_ctrl: hand-computed expectations sampled on the
// falling edge, inputs driven on the falling edge.
module tb_fi_inject_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fi_inject_ctrl_if #(.CNT_W(16), .NUM_TGT(3)) bus ();

  fi_inject_ctrl #(.CNT_W(16), .NUM_TGT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [15:0] dly, input logic [15:0] dur,
                         input logic [2:0] tgt, input logic [1:0] mode);
    bus.cfg_delay    = dly;
    bus.cfg_duration = dur;
    bus.cfg_target   = tgt;
    bus.cfg_mode     = mode;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.obs   = 3'b000;
    set_cfg(16'd0, 16'd1, 3'b001, 2'd0);
    tick();
    tick();

    // Reset state
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_fi_en", 32'(bus.fi_en), 0);
    chk("rst_fi_val", 32'(bus.fi_val), 0);
    chk("rst_snap", 32'(bus.snap), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err_cfg), 0);
    chk("rst_count", 32'(bus.inj_count), 0);
    reset = 1'b0;
    tick();

    // Campaign A: delay 3, duration 2, bit-flip on flop 0, obs 101
    set_cfg(16'd3, 16'd2, 3'b001, 2'd0);
    bus.obs   = 3'b101;
    bus.start = 1'b1;
    tick();                              // edge 0 sampled start
    bus.start = 1'b0;
    set_cfg(16'd0, 16'd9, 3'b111, 2'd2); // must not disturb the active campaign
    chk("a_busy", 32'(bus.busy), 1);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("a_pre_en_e%0d", e), 32'(bus.fi_en), 0);
    end
    chk("a_snap", 32'(bus.snap), 32'b101);
    bus.obs = 3'b000;                    // live obs must not leak into fi_val
    tick();                              // edge 5
    chk("a_en_e5", 32'(bus.fi_en), 32'b001);
    chk("a_val_e5", 32'(bus.fi_val), 0);
    tick();                              // edge 6
    chk("a_en_e6", 32'(bus.fi_en), 32'b001);
    chk("a_val_e6", 32'(bus.fi_val), 0);
    chk("a_done_e6", 32'(bus.done), 0);
    tick();                              // edge 7
    chk("a_en_e7", 32'(bus.fi_en), 0);
    chk("a_done_e7", 32'(bus.done), 1);
    chk("a_count", 32'(bus.inj_count), 1);
    chk("a_busy_end", 32'(bus.busy), 0);

    // Campaign B back-to-back: delay 0, duration 1, stuck-at-1 on 110
    set_cfg(16'd0, 16'd1, 3'b110, 2'd2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("b_accept_busy", 32'(bus.busy), 1);
    chk("b_done_low", 32'(bus.done), 0);
    tick();
    chk("b_en_e1", 32'(bus.fi_en), 0);
    tick();
    chk("b_en_e2", 32'(bus.fi_en), 32'b110);
    chk("b_val_e2", 32'(bus.fi_val), 32'b110);
    tick();
    chk("b_en_e3", 32'(bus.fi_en), 0);
    chk("b_done_e3", 32'(bus.done), 1);
    chk("b_count", 32'(bus.inj_count), 2);

    // Rejected configs: target 0, duration 0, mode 3
    for (int k = 0; k < 3; k++) begin
      set_cfg(16'd0, (k == 1) ? 16'd0 : 16'd1, (k == 0) ? 3'b000 : 3'b001,
              (k == 2) ? 2'd3 : 2'd0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk($sformatf("bad%0d_err", k), 32'(bus.err_cfg), 1);
      chk($sformatf("bad%0d_busy", k), 32'(bus.busy), 0);
      tick();
      chk($sformatf("bad%0d_err_clr", k), 32'(bus.err_cfg), 0);
      chk($sformatf("bad%0d_busy2", k), 32'(bus.busy), 0);
    end
    chk("bad_count", 32'(bus.inj_count), 2);

    // Abort in the second INJECT cycle of a duration-5 stuck-at-0 campaign
    set_cfg(16'd1, 16'd5, 3'b011, 2'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("ab_en_e2", 32'(bus.fi_en), 0);
    tick();
    chk("ab_en_e3", 32'(bus.fi_en), 32'b011);
    chk("ab_val_e3", 32'(bus.fi_val), 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_en_off", 32'(bus.fi_en), 0);
    chk("ab_busy_off", 32'(bus.busy), 0);
    for (int e = 0; e < 3; e++) begin
      tick();
      chk($sformatf("ab_no_done%0d", e), 32'(bus.done), 0);
    end
    chk("ab_count", 32'(bus.inj_count), 2);

    // Abort and start together in IDLE: start is swallowed
    set_cfg(16'd0, 16'd1, 3'b001, 2'd0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa_busy", 32'(bus.busy), 0);
    chk("sa_err", 32'(bus.err_cfg), 0);
    tick();
    chk("sa_busy2", 32'(bus.busy), 0);

    // Start while busy is ignored, then reset during WAIT
    set_cfg(16'd4, 16'd1, 3'b001, 2'd0);
    bus.start = 1'b1;
    tick();
    chk("bz_busy", 32'(bus.busy), 1);
    set_cfg(16'd4, 16'd1, 3'b000, 2'd0);
    tick();
    chk("bz_err1", 32'(bus.err_cfg), 0);
    tick();
    chk("bz_err2", 32'(bus.err_cfg), 0);
    chk("bz_still_busy", 32'(bus.busy), 1);
    bus.start = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rw_busy", 32'(bus.busy), 0);
    chk("rw_count", 32'(bus.inj_count), 0);
    chk("rw_fi_en", 32'(bus.fi_en), 0);
    tick();
    reset = 1'b0;
    tick();

    // New campaign after reset, then reset mid-INJECT
    set_cfg(16'd2, 16'd3, 3'b101, 2'd0);
    bus.obs   = 3'b001;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("c_busy", 32'(bus.busy), 1);
    tick();
    tick();
    tick();
    chk("c_en_e3", 32'(bus.fi_en), 0);
    tick();
    chk("c_en_e4", 32'(bus.fi_en), 32'b101);
    chk("c_val_e4", 32'(bus.fi_val), 32'b100);
    chk("c_snap", 32'(bus.snap), 32'b001);
    #2 reset = 1'b1;
    #1;
    chk("ri_fi_en", 32'(bus.fi_en), 0);
    chk("ri_fi_val", 32'(bus.fi_val), 0);
    chk("ri_snap", 32'(bus.snap), 0);
    chk("ri_busy", 32'(bus.busy), 0);
    tick();
    reset = 1'b0;
    tick();

    // Saturation of inj_count
    force dut.inj_count_q = 16'hFFFE;
    tick();
    release dut.inj_count_q;
    tick();
    chk("sat_preload", 32'(bus.inj_count), 32'hFFFE);
    set_cfg(16'd0, 16'd1, 3'b001, 2'd2);
    for (int r = 0; r < 2; r++) begin
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      chk($sformatf("sat%0d_done", r), 32'(bus.done), 1);
      chk($sformatf("sat%0d_count", r), 32'(bus.inj_count), 32'hFFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
